// File: rtl/vic_nest_ctrl.sv
// ============================================================================
// vic_nest_ctrl -- vectored interrupt controller with a nesting context stack
//
// Picks the highest-priority pending interrupt (lowest index of irq & en),
// redirects fetch to its vector and saves {PC, condition codes, active index}
// of the interrupted context on a small stack. A reti either pops the stack
// (restoring PC and flags) or, when a suitable request is already waiting,
// tail-chains straight into the next ISR while keeping the saved frame.
//
// Build option:
//   VIC_NESTING_EN  defined   -> preemption by higher-priority sources,
//                                stack depth NEST_DEPTH
//                   undefined -> single level (depth 1), no preemption,
//                                tail-chaining still active
//
// Ports:
//   clk                 clock, all state changes on rising edge
//   rst                 synchronous active-high reset
//   i_irq[N_SRC]        level-sensitive interrupt requests
//   i_irq_en[N_SRC]     per-source enable mask
//   i_PC[32]            PC of the instruction in Execute
//   i_CCodes[4]         condition codes of the instruction in Execute
//   i_NOT_FLUSH         Execute holds a valid instruction
//   i_reti              one-cycle pulse: reti in Execute
//   o_IRQ_PC            one-cycle PC-override strobe
//   o_VIC_iaddr[32]     fetch address (vector or restored PC)
//   o_VIC_CCodes[4]     restored condition codes
//   o_VIC_CCodes_ctrl   one-cycle strobe loading o_VIC_CCodes into the flags
//   o_IRQ_VIC           high while any ISR is active
//   o_irq_ack[N_SRC]    one-hot strobe naming the source being entered
//   o_nest_depth        current stack depth
// ============================================================================
module vic_nest_ctrl #(
    parameter int          N_SRC      = 8,
    parameter int          NEST_DEPTH = 4,
    parameter int          VEC_SHIFT  = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_SRC-1:0]                i_irq,
    input  logic [N_SRC-1:0]                i_irq_en,
    input  logic [31:0]                     i_PC,
    input  logic [3:0]                      i_CCodes,
    input  logic                            i_NOT_FLUSH,
    input  logic                            i_reti,
    output logic                            o_IRQ_PC,
    output logic [31:0]                     o_VIC_iaddr,
    output logic [3:0]                      o_VIC_CCodes,
    output logic                            o_VIC_CCodes_ctrl,
    output logic                            o_IRQ_VIC,
    output logic [N_SRC-1:0]                o_irq_ack,
    output logic [$clog2(NEST_DEPTH+1)-1:0] o_nest_depth
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int DW = $clog2(NEST_DEPTH + 1);

`ifdef VIC_NESTING_EN
    localparam int   EFF_DEPTH = NEST_DEPTH;
    localparam logic NEST_ON   = 1'b1;
`else
    localparam int   EFF_DEPTH = 1;
    localparam logic NEST_ON   = 1'b0;
`endif

    localparam int             PW         = (EFF_DEPTH > 1) ? $clog2(EFF_DEPTH) : 1;
    localparam logic [DW-1:0]  DEPTH_MAX  = DW'(EFF_DEPTH);
    localparam logic [DW-1:0]  DEPTH_ONE  = DW'(1);
    localparam logic [DW-1:0]  DEPTH_ZERO = {DW{1'b0}};

    // Event decoded for the current cycle; at most one per cycle.
    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_ENTER  = 2'd1,
        EV_RETURN = 2'd2,
        EV_CHAIN  = 2'd3
    } ev_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    // Lowest set index wins; returns 0 when nothing is pending.
    function automatic logic [IW-1:0] lowest_idx(input logic [N_SRC-1:0] p);
        logic [IW-1:0] r;
        r = {IW{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (p[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [N_SRC-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_SRC-1:0] r;
        r      = {N_SRC{1'b0}};
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] vec_addr(input logic [IW-1:0] idx);
        logic [31:0] off;
        off = 32'(idx);
        return VEC_BASE + (off << VEC_SHIFT);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0]    depth_r;
    logic [IW-1:0]    active_r;
    logic             irq_vic_r;
    logic             irq_pc_r;
    logic             cc_ctrl_r;
    logic [31:0]      iaddr_r;
    logic [3:0]       cc_r;
    logic [N_SRC-1:0] ack_r;

    logic [31:0]      pc_stk_r  [EFF_DEPTH];
    logic [3:0]       cc_stk_r  [EFF_DEPTH];
    logic [IW-1:0]    idx_stk_r [EFF_DEPTH];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] pend_s;
    logic             any_s;
    logic [IW-1:0]    win_s;
    logic             busy_s;
    logic [PW-1:0]    push_ptr_s;
    logic [PW-1:0]    top_ptr_s;
    logic [31:0]      top_pc_s;
    logic [3:0]       top_cc_s;
    logic [IW-1:0]    top_idx_s;
    logic             preempt_ok_s;
    ev_t              ev_s;

    // Pending/winner selection, top-of-stack read and event decode.
    always_comb begin
        pend_s     = i_irq & i_irq_en;
        any_s      = |pend_s;
        win_s      = lowest_idx(pend_s);
        // A strobe is on the outputs this cycle: the pipeline is being
        // redirected, so nothing new may be started until it has gone.
        busy_s     = irq_pc_r | cc_ctrl_r;
        push_ptr_s = PW'(depth_r);

        if (depth_r != DEPTH_ZERO) begin
            top_ptr_s = PW'(depth_r - DEPTH_ONE);
        end else begin
            top_ptr_s = {PW{1'b0}};
        end
        top_pc_s  = pc_stk_r[top_ptr_s];
        top_cc_s  = cc_stk_r[top_ptr_s];
        top_idx_s = idx_stk_r[top_ptr_s];

        preempt_ok_s = (depth_r == DEPTH_ZERO) || (NEST_ON && (win_s < active_r));

        ev_s = EV_NONE;
        if (busy_s) begin
            ev_s = EV_NONE;
        end else if (i_reti) begin
            if (depth_r == DEPTH_ZERO) begin
                ev_s = EV_NONE;
            end else if (any_s && ((depth_r == DEPTH_ONE) || (win_s < top_idx_s))) begin
                // The waiting request would preempt whatever we return to,
                // so go there directly and keep the frame for later.
                ev_s = EV_CHAIN;
            end else begin
                ev_s = EV_RETURN;
            end
        end else if (any_s && i_NOT_FLUSH && (depth_r < DEPTH_MAX) && preempt_ok_s) begin
            ev_s = EV_ENTER;
        end else begin
            ev_s = EV_NONE;
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    // Stack, depth, active index and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_r   <= DEPTH_ZERO;
            active_r  <= {IW{1'b0}};
            irq_vic_r <= 1'b0;
            irq_pc_r  <= 1'b0;
            cc_ctrl_r <= 1'b0;
            iaddr_r   <= 32'h0000_0000;
            cc_r      <= 4'h0;
            ack_r     <= {N_SRC{1'b0}};
            for (int i = 0; i < EFF_DEPTH; i++) begin
                pc_stk_r[i]  <= 32'h0000_0000;
                cc_stk_r[i]  <= 4'h0;
                idx_stk_r[i] <= {IW{1'b0}};
            end
        end else begin
            irq_pc_r  <= 1'b0;
            cc_ctrl_r <= 1'b0;
            ack_r     <= {N_SRC{1'b0}};
            case (ev_s)
                EV_ENTER: begin
                    pc_stk_r[push_ptr_s]  <= i_PC;
                    cc_stk_r[push_ptr_s]  <= i_CCodes;
                    idx_stk_r[push_ptr_s] <= active_r;
                    depth_r               <= depth_r + DEPTH_ONE;
                    active_r              <= win_s;
                    irq_vic_r             <= 1'b1;
                    irq_pc_r              <= 1'b1;
                    iaddr_r               <= vec_addr(win_s);
                    ack_r                 <= onehot(win_s);
                end
                EV_RETURN: begin
                    depth_r   <= depth_r - DEPTH_ONE;
                    active_r  <= top_idx_s;
                    irq_vic_r <= (depth_r != DEPTH_ONE);
                    irq_pc_r  <= 1'b1;
                    cc_ctrl_r <= 1'b1;
                    iaddr_r   <= top_pc_s;
                    cc_r      <= top_cc_s;
                end
                EV_CHAIN: begin
                    active_r <= win_s;
                    irq_pc_r <= 1'b1;
                    iaddr_r  <= vec_addr(win_s);
                    ack_r    <= onehot(win_s);
                end
                default: begin
                    active_r <= active_r;
                end
            endcase
        end
    end

    assign o_IRQ_PC          = irq_pc_r;
    assign o_VIC_iaddr       = iaddr_r;
    assign o_VIC_CCodes      = cc_r;
    assign o_VIC_CCodes_ctrl = cc_ctrl_r;
    assign o_IRQ_VIC         = irq_vic_r;
    assign o_irq_ack         = ack_r;
    assign o_nest_depth      = depth_r;

endmodule

// File: tb/tb_vic_nest_ctrl.sv
// ============================================================================
// tb_vic_nest_ctrl -- scoreboard bench for vic_nest_ctrl (N_SRC=8,
// VEC_SHIFT=4, VEC_BASE=0). Stimulus pushes the expected strobe (with the
// cycle it must appear in) into a queue; a monitor pops and compares every
// time the DUT raises a strobe. Follows VIC_NESTING_EN like the design.
// ============================================================================
module tb_vic_nest_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  irq;
    logic [7:0]  en;
    logic [31:0] pc;
    logic [3:0]  cc;
    logic        nf;
    logic        reti;

    logic        o_IRQ_PC;
    logic [31:0] o_VIC_iaddr;
    logic [3:0]  o_VIC_CCodes;
    logic        o_VIC_CCodes_ctrl;
    logic        o_IRQ_VIC;
    logic [7:0]  o_irq_ack;
    logic [2:0]  o_nest_depth;

    vic_nest_ctrl #(
        .N_SRC      (8),
        .NEST_DEPTH (4),
        .VEC_SHIFT  (4),
        .VEC_BASE   (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_irq             (irq),
        .i_irq_en          (en),
        .i_PC              (pc),
        .i_CCodes          (cc),
        .i_NOT_FLUSH       (nf),
        .i_reti            (reti),
        .o_IRQ_PC          (o_IRQ_PC),
        .o_VIC_iaddr       (o_VIC_iaddr),
        .o_VIC_CCodes      (o_VIC_CCodes),
        .o_VIC_CCodes_ctrl (o_VIC_CCodes_ctrl),
        .o_IRQ_VIC         (o_IRQ_VIC),
        .o_irq_ack         (o_irq_ack),
        .o_nest_depth      (o_nest_depth)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] iaddr;
        logic [3:0]  cc;
        logic        ctrl;
        logic [7:0]  ack;
        logic [2:0]  depth;
        logic        vic;
    } exp_t;

    exp_t        q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] cyc       = 32'd0;
    logic [3:0]  exp_cc;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Vector entry (also used for tail-chain): strobe one cycle later.
    task automatic push_entry(input int idx, input int depth);
        exp_t e;
        logic [31:0] off;
        logic [7:0]  one;
        off     = 32'(idx);
        one     = 8'h01;
        e.cyc   = cyc + 32'd1;
        e.iaddr = off << 4;
        e.cc    = exp_cc;
        e.ctrl  = 1'b0;
        e.ack   = one << idx;
        e.depth = 3'(depth);
        e.vic   = (depth != 0);
        q.push_back(e);
    endtask

    task automatic push_return(input logic [31:0] rpc, input logic [3:0] rcc, input int depth);
        exp_t e;
        e.cyc   = cyc + 32'd1;
        e.iaddr = rpc;
        e.cc    = rcc;
        e.ctrl  = 1'b1;
        e.ack   = 8'h00;
        e.depth = 3'(depth);
        e.vic   = (depth != 0);
        exp_cc  = rcc;
        q.push_back(e);
    endtask

    // Monitor: every strobe must match the next expected event exactly.
    always @(negedge clk) begin
        if (o_IRQ_PC || o_VIC_CCodes_ctrl || (o_irq_ack != 8'h00)) begin
            exp_t e;
            exp_t a;
            total_cnt++;
            a = {cyc, o_VIC_iaddr, o_VIC_CCodes, o_VIC_CCodes_ctrl, o_irq_ack, o_nest_depth, o_IRQ_VIC};
            if (q.size() == 0) begin
                $display("FAIL unexpected_strobe: cyc=%0d irq_pc=%b iaddr=%h ctrl=%b ack=%h, expected no strobe",
                         cyc, o_IRQ_PC, o_VIC_iaddr, o_VIC_CCodes_ctrl, o_irq_ack);
            end else begin
                e = q.pop_front();
                if (o_IRQ_PC && (a === e)) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL strobe: got cyc=%0d pc=%b iaddr=%h cc=%h ctrl=%b ack=%h depth=%0d vic=%b, expected cyc=%0d pc=1 iaddr=%h cc=%h ctrl=%b ack=%h depth=%0d vic=%b",
                             cyc, o_IRQ_PC, o_VIC_iaddr, o_VIC_CCodes, o_VIC_CCodes_ctrl, o_irq_ack, o_nest_depth, o_IRQ_VIC,
                             e.cyc, e.iaddr, e.cc, e.ctrl, e.ack, e.depth, e.vic);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; irq = 8'h00; en = 8'hFF; pc = 32'h0; cc = 4'h0;
        nf = 1'b1; reti = 1'b0; exp_cc = 4'h0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_depth", 32'(o_nest_depth), 32'd0);
        chk("rst_irq_pc", 32'(o_IRQ_PC), 32'd0);
        chk("rst_iaddr", o_VIC_iaddr, 32'h0);
        chk("rst_irq_vic", 32'(o_IRQ_VIC), 32'd0);
        rst = 1'b0;
        tick();

        // Basic entry of source 3
        irq = 8'h08; pc = 32'h100; cc = 4'hA;
        push_entry(3, 1);
        tick(); irq = 8'h00; tick(); tick();
        chk("entry_depth", 32'(o_nest_depth), 32'd1);
        chk("entry_vic", 32'(o_IRQ_VIC), 32'd1);

        // Return restores PC and flags
        reti = 1'b1;
        push_return(32'h100, 4'hA, 0);
        tick(); reti = 1'b0; tick(); tick();

        // Higher-priority request while in ISR 3
        irq = 8'h08; pc = 32'h100; cc = 4'hA;
        push_entry(3, 1);
        tick(); irq = 8'h00; tick(); tick();
        irq = 8'h02; pc = 32'h34; cc = 4'h5;
`ifdef VIC_NESTING_EN
        push_entry(1, 2);
        tick(); irq = 8'h00; tick(); tick();
        chk("nest_depth2", 32'(o_nest_depth), 32'd2);
        reti = 1'b1;
        push_return(32'h34, 4'h5, 1);
        tick(); reti = 1'b0; tick(); tick();
        reti = 1'b1;
        push_return(32'h100, 4'hA, 0);
        tick(); reti = 1'b0; tick(); tick();
`else
        tick(); tick(); tick();
        chk("no_preempt_depth", 32'(o_nest_depth), 32'd1);
        reti = 1'b1;
        push_entry(1, 1);
        tick(); reti = 1'b0; irq = 8'h00; tick(); tick();
        reti = 1'b1;
        push_return(32'h100, 4'hA, 0);
        tick(); reti = 1'b0; tick(); tick();
`endif

        // Request held off by bubbles, then accepted with the valid PC
        irq = 8'h20; nf = 1'b0; pc = 32'h999;
        tick(); tick(); tick();
        nf = 1'b1; pc = 32'h200; cc = 4'h6;
        push_entry(5, 1);
        tick(); irq = 8'h00; tick(); tick();
        reti = 1'b1;
        push_return(32'h200, 4'h6, 0);
        tick(); reti = 1'b0; tick(); tick();

        // Enable mask and priority: pend = 0x28 -> source 3 wins
        irq = 8'h29; en = 8'hFE; pc = 32'h300; cc = 4'h1;
        push_entry(3, 1);
        tick(); irq = 8'h00; en = 8'hFF; tick(); tick();
        reti = 1'b1;
        push_return(32'h300, 4'h1, 0);
        tick(); reti = 1'b0; tick(); tick();

        // Tail-chain at depth 1, then return to original PC
        irq = 8'h04; pc = 32'h80; cc = 4'hC;
        push_entry(2, 1);
        tick(); irq = 8'h00; tick(); tick();
        irq = 8'h40; reti = 1'b1;
        push_entry(6, 1);
        tick(); reti = 1'b0; irq = 8'h00; tick(); tick();
        chk("chain_depth", 32'(o_nest_depth), 32'd1);
        reti = 1'b1;
        push_return(32'h80, 4'hC, 0);
        tick(); reti = 1'b0; tick(); tick();

        // Reset right after an accept, then a stray reti
        irq = 8'h10; pc = 32'h500; cc = 4'h7;
        push_entry(4, 1);
        tick(); rst = 1'b1; irq = 8'h00;
        tick(); rst = 1'b0; exp_cc = 4'h0;
        chk("abort_depth", 32'(o_nest_depth), 32'd0);
        chk("abort_vic", 32'(o_IRQ_VIC), 32'd0);
        chk("abort_iaddr", o_VIC_iaddr, 32'h0);
        chk("abort_ccodes", 32'(o_VIC_CCodes), 32'd0);
        reti = 1'b1;
        tick(); reti = 1'b0; tick(); tick();

        // Request present during reset is taken right after release
        rst = 1'b1; irq = 8'h04; pc = 32'h40; cc = 4'h3;
        tick(); tick();
        rst = 1'b0;
        push_entry(2, 1);
        tick(); irq = 8'h00; tick(); tick();
        chk("post_rst_depth", 32'(o_nest_depth), 32'd1);

        tick();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vic_nest_ctrl.md
VIC_NEST_CTRL -- requirements
Module: vic_nest_ctrl

Interface
REQ-001 Parameter N_SRC, default 8, number of interrupt sources; index 0 is highest priority.
REQ-002 Parameter NEST_DEPTH, default 4, number of context-stack frames.
REQ-003 Parameter VEC_SHIFT, default 4, left shift applied to the source index to form the vector offset.
REQ-004 Parameter VEC_BASE, default 32'h0000_0000, base address added to every vector.
REQ-005 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port: rst, input, 1, synchronous active-high reset.
REQ-007 Port: i_irq, input, N_SRC, level-sensitive interrupt requests.
REQ-008 Port: i_irq_en, input, N_SRC, per-source enable mask.
REQ-009 Port: i_PC, input, 32, PC of the instruction in Execute.
REQ-010 Port: i_CCodes, input, 4, condition codes of the instruction in Execute.
REQ-011 Port: i_NOT_FLUSH, input, 1, high when Execute holds a valid instruction, not a bubble.
REQ-012 Port: i_reti, input, 1, one-cycle pulse when a reti is in Execute.
REQ-013 Port: o_IRQ_PC, output, 1, one-cycle PC-override strobe.
REQ-014 Port: o_VIC_iaddr, output, 32, fetch address, valid while o_IRQ_PC is high.
REQ-015 Port: o_VIC_CCodes, output, 4, restored condition codes.
REQ-016 Port: o_VIC_CCodes_ctrl, output, 1, one-cycle strobe that loads o_VIC_CCodes into the flags.
REQ-017 Port: o_IRQ_VIC, output, 1, high while any ISR is active (depth>0).
REQ-018 Port: o_irq_ack, output, N_SRC, one-hot one-cycle strobe naming the source being entered.
REQ-019 Port: o_nest_depth, output, $clog2(NEST_DEPTH+1), current stack depth.

Function
REQ-020 pend = i_irq & i_irq_en; the winner SHALL be the lowest set index of pend.
REQ-021 Accept SHALL occur when pend!=0, i_NOT_FLUSH=1, i_reti=0, depth<NEST_DEPTH, and either depth=0 or the winner index is lower than the active index.
REQ-022 On accept, the block SHALL push {i_PC, i_CCodes, active index} and increment depth. The winner becomes active.
REQ-023 Accept outputs SHALL be registered and appear in the next cycle: o_IRQ_PC=1, o_VIC_iaddr=VEC_BASE+(winner<<VEC_SHIFT), o_irq_ack[winner]=1, each for exactly one cycle.
REQ-024 A request blocked only by i_NOT_FLUSH=0 SHALL be retried every cycle and never dropped, while it stays asserted.
REQ-025 On i_reti with depth>0 and no tail-chain, the block SHALL pop the stack. In the next cycle it SHALL drive o_VIC_iaddr=saved PC, o_VIC_CCodes=saved CC, o_IRQ_PC=1 and o_VIC_CCodes_ctrl=1 for one cycle. The active index SHALL be restored from the frame.
REQ-026 Tail-chain: on i_reti with a winner that beats the popped frame's active index (or depth=1 and pend!=0), the top frame SHALL be retained and depth SHALL be unchanged. The block SHALL enter the winner per REQ-023, with o_VIC_CCodes_ctrl=0.
REQ-027 i_reti with depth=0 SHALL be ignored; no output strobes.
REQ-028 At depth=NEST_DEPTH, no preemption SHALL occur; requests wait for reti.
REQ-029 o_IRQ_PC and o_VIC_CCodes_ctrl SHALL never be high on consecutive cycles from separate events; the cycle after a strobe SHALL ignore new accepts.
REQ-030 o_VIC_iaddr and o_VIC_CCodes SHALL hold their last values when not strobed.

Reset
REQ-031 rst=1 at a rising edge SHALL clear every output, depth, active index and all stack frames to 0, aborting any in-flight entry or return.
REQ-032 Requests present during reset SHALL be evaluated from the first cycle after rst deasserts.

Configuration
REQ-033 With VIC_NESTING_EN defined, preemption per REQ-021 and stack depth NEST_DEPTH SHALL apply.
REQ-034 Without VIC_NESTING_EN, the effective depth SHALL be 1 and accept SHALL require depth=0. Tail-chain per REQ-026 SHALL remain.

Verification (N_SRC=8, VEC_SHIFT=4, VEC_BASE=0)
REQ-035 i_irq[3]=1, en=FF, i_PC=0x100, CC=4'hA, NOT_FLUSH=1 -> next cycle o_IRQ_PC=1, iaddr=0x30, ack=0x08, depth=1.
REQ-036 reti from REQ-035 state -> next cycle iaddr=0x100, o_VIC_CCodes=4'hA, CCodes_ctrl=1, o_IRQ_PC=1, depth=0, o_IRQ_VIC=0.
REQ-037 While in ISR 3, i_irq[1]=1, i_PC=0x34 -> iaddr=0x10, depth=2. Two retis return to 0x34, then to 0x100. Without VIC_NESTING_EN, ISR 1 waits and is tail-chained at the first reti.
REQ-038 i_irq[5]=1, NOT_FLUSH=0 for 3 cycles then 1 with i_PC=0x200 -> no strobe for 3 cycles. Entry iaddr=0x50, saved PC=0x200.
REQ-039 reti with i_irq[6] pending at depth=1 -> iaddr=0x60, CCodes_ctrl=0, depth stays 1. The next reti returns to the original PC.
REQ-040 rst asserted the cycle after accept -> all outputs 0 and depth=0 next cycle. A stray reti afterwards produces no strobe.
